// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register load arbiter.
// Contents:
//   state_e          - arbiter FSM encoding (IDLE / GRANT / ACK)
//   REG_WIDTH_DEF    - default width of the shared register
//   GNT_ID_W         - width of the winner index (supports up to 8 requesters)
//   rr_next()        - round-robin successor of an index, wrapping at n
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_ACK   = 2'b10
    } state_e;

    localparam int REG_WIDTH_DEF = 16;
    localparam int GNT_ID_W      = 3;

    // Index following id in a ring of n requesters.
    function automatic logic [GNT_ID_W-1:0] rr_next(input logic [GNT_ID_W-1:0] id,
                                                    input int n);
        if (id == GNT_ID_W'(n - 1)) begin
            return {GNT_ID_W{1'b0}};
        end else begin
            return id + 3'd1;
        end
    endfunction

endpackage

// File: rtl/register_load_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req    in  NUM_REQ   request vector
//   ptr    in  GNT_ID_W  index with highest priority this round
//   found  out 1         at least one request is set
//   win_id out GNT_ID_W  first set bit at or above ptr, wrapping to bit 0
module rr_picker
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [GNT_ID_W-1:0] ptr,
    output logic                found,
    output logic [GNT_ID_W-1:0] win_id
);

    logic                found_hi_s;
    logic [GNT_ID_W-1:0] win_hi_s;
    logic                found_lo_s;
    logic [GNT_ID_W-1:0] win_lo_s;

    // Two scans: lowest set bit at or above ptr, and lowest set bit below ptr.
    // The upper scan has priority, which gives the wrap-around order.
    always_comb begin
        found_hi_s = 1'b0;
        win_hi_s   = {GNT_ID_W{1'b0}};
        found_lo_s = 1'b0;
        win_lo_s   = {GNT_ID_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (GNT_ID_W'(i) >= ptr) && !found_hi_s) begin
                found_hi_s = 1'b1;
                win_hi_s   = GNT_ID_W'(i);
            end else if (req[i] && (GNT_ID_W'(i) < ptr) && !found_lo_s) begin
                found_lo_s = 1'b1;
                win_lo_s   = GNT_ID_W'(i);
            end else begin
                found_lo_s = found_lo_s;
            end
        end
    end

    // Merge the two scans into the final winner.
    always_comb begin
        found = found_hi_s | found_lo_s;
        if (found_hi_s) begin
            win_id = win_hi_s;
        end else begin
            win_id = win_lo_s;
        end
    end

endmodule

// File: rtl/register_load_arbiter.sv
// register_load_arbiter: round-robin owner of all writes to a shared
// load-enabled register, with a 4-phase req/ack handshake per requester.
// Ports:
//   clk       in  1               rising-edge clock
//   rst       in  1               synchronous, active-low reset
//   req       in  NUM_REQ         per-requester level request
//   req_data  in  NUM_REQ*WIDTH   slice i = bits [i*WIDTH +: WIDTH]
//   ack       out NUM_REQ         one-hot, load of requester gnt_id complete
//   reg_ld    out 1               shared register load enable (GRANT only)
//   reg_in    out WIDTH           shared register data (0 outside GRANT)
//   gnt_id    out 3               current or last winner
//   busy      out 1               high in GRANT or ACK
module register_load_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = REG_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     reg_ld,
    output logic [WIDTH-1:0]         reg_in,
    output logic [GNT_ID_W-1:0]      gnt_id,
    output logic                     busy
);

    state_e              state_q, state_d;
    logic [GNT_ID_W-1:0] ptr_q, ptr_d;
    logic [GNT_ID_W-1:0] gnt_id_q, gnt_id_d;

    logic                pick_found_s;
    logic [GNT_ID_W-1:0] pick_id_s;
    logic                req_sel_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req    (req),
        .ptr    (ptr_q),
        .found  (pick_found_s),
        .win_id (pick_id_s)
    );

    // Request level of the current winner (mux written as a loop so the
    // 3-bit index never has to be narrowed to the vector width).
    always_comb begin
        req_sel_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_q == GNT_ID_W'(i)) begin
                req_sel_s = req[i];
            end else begin
                req_sel_s = req_sel_s;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, one load cycle, hold ACK until release.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    gnt_id_d = pick_id_s;
                    state_d  = ST_GRANT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // Pointer moves past the winner only here, so a requester
                // that re-requests at once cannot beat a pending neighbour.
                if (!req_sel_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = rr_next(gnt_id_q, NUM_REQ);
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {GNT_ID_W{1'b0}};
            gnt_id_q <= {GNT_ID_W{1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // Output decode from registered state and winner index only.
    always_comb begin
        reg_ld = (state_q == ST_GRANT);
        busy   = (state_q != ST_IDLE);
        gnt_id = gnt_id_q;
        reg_in = {WIDTH{1'b0}};
        ack    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_q == GNT_ID_W'(i)) begin
                ack[i] = (state_q == ST_ACK);
                if (state_q == ST_GRANT) begin
                    reg_in = req_data[i*WIDTH +: WIDTH];
                end else begin
                    reg_in = {WIDTH{1'b0}};
                end
            end else begin
                ack[i] = 1'b0;
            end
        end
    end

endmodule
